// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared FSM encoding, header defaults and error codes for uart_frame_ctrl
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HDR1,
    ST_GET_CMD,
    ST_GET_LEN,
    ST_GET_PAY,
    ST_GET_CHK,
    ST_HOLD
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  localparam logic [2:0] ERR_CHK = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_TMO = 3'd3;
  localparam logic [2:0] ERR_OVR = 3'd4;

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - inter-byte timeout counter; expire is suppressed in a cycle where clr is high
module uart_frame_timer #(
  parameter int LIMIT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - frame assembler/validator behind the byte UART receiver
// Optional inter-byte timeout is built only when RX_TIMEOUT_EN is defined.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter logic [7:0] HDR0         = HDR0_DEF,
  parameter logic [7:0] HDR1         = HDR1_DEF,
  parameter int         BYTE_TIMEOUT = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_busy,
  input  logic [7:0]           rx_data,
  output logic                 frm_valid,
  input  logic                 frm_ready,
  output logic [7:0]           frm_cmd,
  output logic [3:0]           frm_len,
  output logic [MAX_LEN*8-1:0] frm_payload,
  output logic                 frm_err,
  output logic [2:0]           frm_err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state, state_next;
  logic       busy_d;
  logic       strobe;
  logic [3:0] cnt;
  logic [7:0] sum;
  logic       tmo_expire;

  logic       err_set;
  logic [2:0] err_code_next;
  logic       cmd_ld, len_ld, pay_clr, pay_wr, sum_clr, sum_add, cnt_clr, cnt_inc;

  assign strobe    = busy_d & ~rx_busy;
  assign frm_valid = (state == ST_HOLD);

`ifdef RX_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state != ST_IDLE) && (state != ST_HOLD);

  uart_frame_timer #(
    .LIMIT(BYTE_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (strobe),
    .en    (tmo_en),
    .expire(tmo_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (BYTE_TIMEOUT == 0);
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy_d <= 1'b0;
    end else begin
      state  <= state_next;
      busy_d <= rx_busy;
    end
  end

  always_comb begin
    state_next    = state;
    err_set       = 1'b0;
    err_code_next = frm_err_code;
    cmd_ld        = 1'b0;
    len_ld        = 1'b0;
    pay_clr       = 1'b0;
    pay_wr        = 1'b0;
    sum_clr       = 1'b0;
    sum_add       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    if (tmo_expire) begin
      state_next    = ST_IDLE;
      err_set       = 1'b1;
      err_code_next = ERR_TMO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe && rx_data == HDR0) state_next = ST_WAIT_HDR1;
        end
        ST_WAIT_HDR1: begin
          if (strobe) begin
            if (rx_data == HDR1) begin
              state_next = ST_GET_CMD;
              sum_clr    = 1'b1;
            end else if (rx_data != HDR0) begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_GET_CMD: begin
          if (strobe) begin
            cmd_ld     = 1'b1;
            pay_clr    = 1'b1;
            sum_add    = 1'b1;
            state_next = ST_GET_LEN;
          end
        end
        ST_GET_LEN: begin
          if (strobe) begin
            if (rx_data > MAX_LEN_B) begin
              err_set       = 1'b1;
              err_code_next = ERR_LEN;
              state_next    = ST_IDLE;
            end else begin
              len_ld     = 1'b1;
              sum_add    = 1'b1;
              cnt_clr    = 1'b1;
              state_next = (rx_data == 8'd0) ? ST_GET_CHK : ST_GET_PAY;
            end
          end
        end
        ST_GET_PAY: begin
          if (strobe) begin
            pay_wr  = 1'b1;
            sum_add = 1'b1;
            if (cnt == frm_len - 4'd1) begin
              cnt_clr    = 1'b1;
              state_next = ST_GET_CHK;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_GET_CHK: begin
          if (strobe) begin
            if (rx_data == sum) begin
              state_next = ST_HOLD;
            end else begin
              err_set       = 1'b1;
              err_code_next = ERR_CHK;
              state_next    = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          // A byte arriving with the accepting handshake is treated as the first IDLE byte.
          if (frm_ready) begin
            state_next = (strobe && rx_data == HDR0) ? ST_WAIT_HDR1 : ST_IDLE;
          end else if (strobe) begin
            err_set       = 1'b1;
            err_code_next = ERR_OVR;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cmd      <= '0;
      frm_len      <= '0;
      frm_payload  <= '0;
      frm_err      <= 1'b0;
      frm_err_code <= '0;
      cnt          <= '0;
      sum          <= '0;
    end else begin
      frm_err      <= err_set;
      frm_err_code <= err_code_next;
      if (cmd_ld) frm_cmd <= rx_data;
      if (len_ld) frm_len <= rx_data[3:0];
      if (sum_clr) sum <= '0;
      else if (sum_add) sum <= sum + rx_data;
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 4'd1;
      if (pay_clr) begin
        frm_payload <= '0;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (pay_wr && cnt == 4'(i)) frm_payload[i*8 +: 8] <= rx_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [7:0]  frm_cmd;
  logic [3:0]  frm_len;
  logic [63:0] frm_payload;
  logic        frm_err;
  logic [2:0]  frm_err_code;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_base;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .MAX_LEN(8),
    .HDR0(8'hAA),
    .HDR1(8'h55),
    .BYTE_TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_busy(rx_busy),
    .rx_data(rx_data),
    .frm_valid(frm_valid),
    .frm_ready(frm_ready),
    .frm_cmd(frm_cmd),
    .frm_len(frm_len),
    .frm_payload(frm_payload),
    .frm_err(frm_err),
    .frm_err_code(frm_err_code)
  );

  always @(negedge clk) if (rst_n && frm_err) err_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    rx_data = b;
    rx_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic handshake();
    frm_ready = 1'b1;
    @(negedge clk);
    frm_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", frm_valid, 0);
    check("rst_err", frm_err, 0);
    check("rst_code", frm_err_code, 0);
    check("rst_cmd", frm_cmd, 0);
    check("rst_len", frm_len, 0);
    check("rst_payload", frm_payload, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // good frame with ready held high: valid for exactly one cycle
    frm_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h15);
    check("good_valid", frm_valid, 1);
    check("good_cmd", frm_cmd, 8'h10);
    check("good_len", frm_len, 2);
    check("good_payload", frm_payload, 64'h0201);
    @(negedge clk);
    check("good_valid_drop", frm_valid, 0);
    frm_ready = 1'b0;
    check("good_no_err", err_seen, 0);

    // zero length
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h21); send_byte(8'h00); send_byte(8'h21);
    check("zero_valid", frm_valid, 1);
    check("zero_cmd", frm_cmd, 8'h21);
    check("zero_len", frm_len, 0);
    check("zero_payload", frm_payload, 0);
    handshake();
    check("zero_accepted", frm_valid, 0);

    // bad checksum, then a good frame
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h01);
    send_byte(8'h05); send_byte(8'h00);
    check("chk_err", frm_err, 1);
    check("chk_code", frm_err_code, 3'd1);
    check("chk_no_valid", frm_valid, 0);
    @(negedge clk);
    check("chk_pulse_end", frm_err, 0);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h07); send_byte(8'h3B);
    check("after_chk_valid", frm_valid, 1);
    check("after_chk_payload", frm_payload, 64'h07);
    handshake();

    // length overflow, then resync on repeated header byte
    err_base = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h09);
    check("len_err", frm_err, 1);
    check("len_code", frm_err_code, 3'd2);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h10);
    check("resync_valid", frm_valid, 1);
    check("resync_len", frm_len, 0);
    check("len_err_count", err_seen - err_base, 1);
    handshake();

    // maximum length frame
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h40); send_byte(8'h08);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h6C);
    check("max_valid", frm_valid, 1);
    check("max_len", frm_len, 8);
    check("max_payload", frm_payload, 64'h0807060504030201);
    handshake();

    // overrun in HOLD, then ready coinciding with an HDR0 strobe
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h15);
    check("ovr_hold_valid", frm_valid, 1);
    send_byte(8'h33);
    check("ovr_err", frm_err, 1);
    check("ovr_code", frm_err_code, 3'd4);
    check("ovr_still_valid", frm_valid, 1);
    check("ovr_cmd", frm_cmd, 8'h10);
    check("ovr_payload", frm_payload, 64'h0201);
    @(negedge clk);
    check("ovr_code_held", frm_err_code, 3'd4);
    @(negedge clk);
    rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    rx_data = 8'hAA;
    rx_busy = 1'b0;
    frm_ready = 1'b1;
    @(negedge clk);
    frm_ready = 1'b0;
    check("ovr_handshake", frm_valid, 0);
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h00); send_byte(8'h10);
    check("ovr_next_frame", frm_valid, 1);
    handshake();

    // reset mid-payload
    err_base = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h04); send_byte(8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", frm_cmd, 0);
    check("mid_rst_len", frm_len, 0);
    check("mid_rst_err", frm_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h1A);
    check("mid_rst_discard", frm_valid, 0);
    check("mid_rst_no_err", err_seen - err_base, 0);

`ifdef RX_TIMEOUT_EN
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
    repeat (99) @(negedge clk);
    check("tmo_not_yet", frm_err, 0);
    @(negedge clk);
    check("tmo_err", frm_err, 1);
    check("tmo_code", frm_err_code, 3'd3);
    send_byte(8'h00); send_byte(8'h10);
    check("tmo_idle", frm_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
